// File: rtl/mux_scan_pkg.sv
// Shared constants and types for the mux scan sequencer.
package mux_scan_pkg;

    // One sample per mux channel, packed a..d into bits 0..3.
    localparam int FRAME_W = 4;

    // Channel numbers as driven onto {s0,s1}.
    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    // Sequencer states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Dwell counter: counts 0..DWELL_CYCLES-1 while enabled and flags the last count.
// clear has priority over enable and forces the count back to zero.
module dwell_timer #(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    // Next count: clear, wrap at terminal count, otherwise increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the selects through a..d, samples the
// mux output at the end of each dwell and publishes a 4-bit frame.
//
// Protocol: start is a level sampled only in IDLE (abort wins). frame_valid is
// a one-cycle pulse with no back-pressure; frame holds its value until the next
// complete scan, and aborted or reset scans never produce a pulse.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cont,
    input  logic               abort,
    input  logic               mux_out,
    output logic               s0,
    output logic               s1,
    output logic               busy,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid
);

    state_e             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [2:0]         shadow_q, shadow_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               fv_q, fv_d;

    logic timer_clear;
    logic timer_en;
    logic timer_tc;

    // Counter is held at zero outside a scan and restarted on abort.
    assign timer_clear = (state_q == ST_IDLE) || abort;
    assign timer_en    = (state_q == ST_SCAN);

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES),
        .CNT_W       (CNT_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (timer_clear),
        .enable_i(timer_en),
        .tc_o    (timer_tc)
    );

    // Selects come straight from the channel register, so they only move on edges.
    assign s0          = ch_q[1];
    assign s1          = ch_q[0];
    assign busy        = (state_q == ST_SCAN);
    assign frame       = frame_q;
    assign frame_valid = fv_q;

    // Next-state: start/abort handling, per-channel sampling and frame commit.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        fv_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_SCAN;
                    ch_d    = CH_A;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    ch_d    = CH_A;
                end else if (timer_tc) begin
                    ch_d = ch_q + 2'd1;
                    case (ch_q)
                        CH_A:    shadow_d[0] = mux_out;
                        CH_B:    shadow_d[1] = mux_out;
                        CH_C:    shadow_d[2] = mux_out;
                        default: begin
                            frame_d = {mux_out, shadow_q};
                            fv_d    = 1'b1;
                            if (!cont) begin
                                state_d = ST_IDLE;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = CH_A;
            end
        endcase
    end

    // State, channel, shadow and frame registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ch_q     <= CH_A;
            shadow_q <= '0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            fv_q     <= fv_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a default-dwell instance and a DWELL_CYCLES=1
// instance, each feeding its selects into a behavioural 4:1 mux.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    int         checks = 0;
    int         errors = 0;

    // Default instance (DWELL_CYCLES = 4). chan = {d,c,b,a}.
    logic       start, cont, abort;
    logic [3:0] chan;
    logic       mux_out;
    logic       s0, s1, busy, frame_valid;
    logic [3:0] frame;
    assign mux_out = chan[{s0, s1}];

    mux_scan_ctrl #(.DWELL_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .mux_out(mux_out), .s0(s0), .s1(s1), .busy(busy), .frame(frame),
        .frame_valid(frame_valid)
    );

    // Single-cycle dwell instance.
    logic       start2, cont2, abort2;
    logic [3:0] chan2;
    logic       mux_out2;
    logic       s0_2, s1_2, busy2, frame_valid2;
    logic [3:0] frame2;
    assign mux_out2 = chan2[{s0_2, s1_2}];

    mux_scan_ctrl #(.DWELL_CYCLES(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cont(cont2), .abort(abort2),
        .mux_out(mux_out2), .s0(s0_2), .s1(s1_2), .busy(busy2), .frame(frame2),
        .frame_valid(frame_valid2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge on the default instance; returns #1 after that edge (E0).
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; cont = 0; abort = 0; chan = 4'h0;
        start2 = 0; cont2 = 0; abort2 = 0; chan2 = 4'h0;
        #12;
        checks++;
        if ({s0, s1, busy, frame, frame_valid} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000", {s0, s1, busy, frame, frame_valid});
        end
        checks++;
        if ({s0_2, s1_2, busy2, frame2, frame_valid2} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs_d1: got %b expected 00000000", {s0_2, s1_2, busy2, frame2, frame_valid2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single();
        logic [1:0] es;
        chan = 4'b0001; cont = 1'b0;
        pulse_start();
        checks++;
        if ({busy, s0, s1} !== 3'b100) begin
            errors++;
            $display("FAIL single_start: got busy/sel %b expected 100", {busy, s0, s1});
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i < 16) begin
                es = 2'(i / 4);
                checks++;
                if ({s0, s1} !== es || frame_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_step%0d: got sel=%b fv=%b busy=%b expected sel=%b fv=0 busy=1",
                             i, {s0, s1}, frame_valid, busy, es);
                end
            end else begin
                checks++;
                if (frame_valid !== 1'b1 || frame !== 4'b0001 || busy !== 1'b0 || {s0, s1} !== 2'b00) begin
                    errors++;
                    $display("FAIL single_frame: got fv=%b frame=%b busy=%b sel=%b expected fv=1 frame=0001 busy=0 sel=00",
                             frame_valid, frame, busy, {s0, s1});
                end
            end
        end
        tick();
        checks++;
        if (frame_valid !== 1'b0 || frame !== 4'b0001) begin
            errors++;
            $display("FAIL single_pulse_end: got fv=%b frame=%b expected fv=0 frame=0001", frame_valid, frame);
        end
    endtask

    task automatic test_continuous();
        chan = 4'b0110; cont = 1'b1;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            for (int i = 1; i <= 16; i++) begin
                tick();
                if (f == 1 && i == 4) chan[3] = 1'b1;
                if (i < 16) begin
                    checks++;
                    if (frame_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL cont_nopulse f%0d i%0d: got fv=%b expected 0", f, i, frame_valid);
                    end
                end else begin
                    checks++;
                    if (frame_valid !== 1'b1 || frame !== ((f == 0) ? 4'b0110 : 4'b1110) ||
                        busy !== (f < 2)) begin
                        errors++;
                        $display("FAIL cont_frame%0d: got fv=%b frame=%b busy=%b expected fv=1 frame=%b busy=%b",
                                 f, frame_valid, frame, busy, (f == 0) ? 4'b0110 : 4'b1110, f < 2);
                    end
                end
            end
            if (f == 1) cont = 1'b0;
        end
    endtask

    task automatic test_abort_mid();
        int pulses;
        chan = 4'b1111;
        pulse_start();
        for (int i = 1; i <= 6; i++) tick();
        checks++;
        if ({s0, s1} !== 2'b01) begin
            errors++;
            $display("FAIL abort_mid_chan: got sel=%b expected 01", {s0, s1});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || {s0, s1} !== 2'b00 || frame_valid !== 1'b0 || frame !== 4'b1110) begin
            errors++;
            $display("FAIL abort_mid: got busy=%b sel=%b fv=%b frame=%b expected busy=0 sel=00 fv=0 frame=1110",
                     busy, {s0, s1}, frame_valid, frame);
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (frame_valid === 1'b1 || busy !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0 || frame !== 4'b1110) begin
            errors++;
            $display("FAIL abort_mid_quiet: got %0d active cycles frame=%b expected 0 frame=1110", pulses, frame);
        end
    endtask

    task automatic test_abort_sample();
        chan = 4'b0101; cont = 1'b0;
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 7) start = 1'b1;
            if (i == 8) start = 1'b0;
            if (i < 16) begin
                checks++;
                if (frame_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_start_step%0d: got fv=%b busy=%b expected fv=0 busy=1", i, frame_valid, busy);
                end
            end else begin
                checks++;
                if (frame_valid !== 1'b1 || frame !== 4'b0101 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_start_frame: got fv=%b frame=%b busy=%b expected fv=1 frame=0101 busy=0",
                             frame_valid, frame, busy);
                end
            end
        end
        tick();
        chan = 4'b1010;
        pulse_start();
        for (int i = 1; i <= 15; i++) tick();
        checks++;
        if ({s0, s1} !== 2'b11) begin
            errors++;
            $display("FAIL abort_d_chan: got sel=%b expected 11", {s0, s1});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (frame_valid !== 1'b0 || frame !== 4'b0101 || busy !== 1'b0 || {s0, s1} !== 2'b00) begin
            errors++;
            $display("FAIL abort_d_sample: got fv=%b frame=%b busy=%b sel=%b expected fv=0 frame=0101 busy=0 sel=00",
                     frame_valid, frame, busy, {s0, s1});
        end
        tick();
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_d_after: got fv=%b expected 0", frame_valid);
        end
    endtask

    task automatic test_reset_mid();
        chan = 4'b1001;
        pulse_start();
        for (int i = 1; i <= 10; i++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s0, s1, busy, frame, frame_valid} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: got %b expected 00000000", {s0, s1, busy, frame, frame_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        for (int i = 1; i <= 16; i++) tick();
        checks++;
        if (frame_valid !== 1'b1 || frame !== 4'b1001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_rescan: got fv=%b frame=%b busy=%b expected fv=1 frame=1001 busy=0",
                     frame_valid, frame, busy);
        end
    endtask

    task automatic test_dwell1();
        logic [1:0] es;
        chan2 = 4'hF; cont2 = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        checks++;
        if ({busy2, s0_2, s1_2} !== 3'b100) begin
            errors++;
            $display("FAIL dwell1_start: got busy/sel %b expected 100", {busy2, s0_2, s1_2});
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i < 4) begin
                es = 2'(i);
                checks++;
                if ({s0_2, s1_2} !== es || frame_valid2 !== 1'b0) begin
                    errors++;
                    $display("FAIL dwell1_step%0d: got sel=%b fv=%b expected sel=%b fv=0", i, {s0_2, s1_2}, frame_valid2, es);
                end
            end else begin
                checks++;
                if (frame_valid2 !== 1'b1 || frame2 !== 4'hF || busy2 !== 1'b0 || {s0_2, s1_2} !== 2'b00) begin
                    errors++;
                    $display("FAIL dwell1_frame: got fv=%b frame=%h busy=%b sel=%b expected fv=1 frame=f busy=0 sel=00",
                             frame_valid2, frame2, busy2, {s0_2, s1_2});
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_abort_mid();
        test_abort_sample();
        test_reset_mid();
        test_dwell1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
